// File: rtl/game_sprite_control_multi_pkg.sv
// Shared types for the sprite motion engine: edge behaviour, sweep FSM states,
// and the speed negation used when a sprite bounces.
package game_sprite_pkg;

  typedef enum logic [1:0] {
    BOUNCE = 2'd0,
    WRAP   = 2'd1,
    STOP   = 2'd2,
    FREEZE = 2'd3
  } edge_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Two's-complement negate of a w-bit value; the most negative input maps to
  // the most positive one instead of overflowing back onto itself.
  function automatic int sat_neg(input int v, input int unsigned w);
    int min_v;
    min_v = -(1 << (w - 1));
    if (v == min_v) return -(min_v + 1);
    return -v;
  endfunction

endpackage

// File: rtl/game_sprite_axis_step.sv
// One motion step along a single axis: applies the speed, then resolves the
// screen edge according to the sprite's edge mode.
module game_sprite_axis_step
  import game_sprite_pkg::*;
#(
  parameter int unsigned W      = 10,
  parameter int unsigned SW     = 4,
  parameter int unsigned LIMIT  = 632,
  parameter int unsigned SCREEN = 640
) (
  input  logic [W-1:0]  pos_i,
  input  logic [SW-1:0] speed_i,
  input  logic [1:0]    mode_i,
  output logic [W-1:0]  pos_o,
  output logic [SW-1:0] speed_o,
  output logic          hit_o
);

  localparam int unsigned XW = W + 2;
  localparam logic signed [XW-1:0] LIM_S = XW'(LIMIT);
  localparam logic signed [XW-1:0] SCR_S = XW'(SCREEN);

  edge_mode_e             mode;
  logic signed [XW-1:0]   pos_s;
  logic signed [XW-1:0]   spd_s;
  logic signed [XW-1:0]   nxt_s;
  logic [SW-1:0]          neg_spd;

  assign mode    = edge_mode_e'(mode_i);
  assign pos_s   = $signed({2'b00, pos_i});
  assign spd_s   = $signed({{(XW - SW){speed_i[SW-1]}}, speed_i});
  assign nxt_s   = pos_s + spd_s;
  assign neg_spd = SW'(sat_neg(int'(spd_s), SW));

  always_comb begin
    pos_o   = pos_i;
    speed_o = speed_i;
    hit_o   = 1'b0;
    case (mode)
      BOUNCE, STOP: begin
        if (nxt_s[XW-1]) begin
          pos_o   = '0;
          speed_o = (mode == STOP) ? '0 : neg_spd;
          hit_o   = 1'b1;
        end else if (nxt_s > LIM_S) begin
          pos_o   = W'(LIMIT);
          speed_o = (mode == STOP) ? '0 : neg_spd;
          hit_o   = 1'b1;
        end else begin
          pos_o = W'(nxt_s);
        end
      end
      WRAP: begin
        if (nxt_s[XW-1]) begin
          pos_o = W'(nxt_s + SCR_S);
          hit_o = 1'b1;
        end else if (nxt_s >= SCR_S) begin
          pos_o = W'(nxt_s - SCR_S);
          hit_o = 1'b1;
        end else begin
          pos_o = W'(nxt_s);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/game_strobe.sv
// Free-running counter that pulses strobe_o for one cycle every 2**width cycles.
module game_strobe #(
  parameter int unsigned width = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic strobe_o
);

  logic [width-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_q + width'(1);
  end

  assign strobe_o = &cnt_q;

endmodule

// File: rtl/game_sprite_control_multi.sv
// Position/velocity engine for N_SPRITES sprites; a periodic sweep steps one
// sprite per clock through a single shared pair of axis step units.
module game_sprite_control_multi
  import game_sprite_pkg::*;
#(
  parameter int unsigned N_SPRITES     = 4,
  parameter int unsigned SPRITE_WIDTH  = 8,
  parameter int unsigned SPRITE_HEIGHT = 8,
  parameter int unsigned DX_WIDTH      = 4,
  parameter int unsigned DY_WIDTH      = 4,
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height),
  parameter int unsigned w_idx         = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  parameter int unsigned strobe_to_update_xy_counter_width = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [w_idx-1:0]         wr_idx,
  input  logic                     write_xy,
  input  logic                     write_dxy,
  input  logic                     write_mode,
  input  logic [w_x-1:0]           wr_x,
  input  logic [w_y-1:0]           wr_y,
  input  logic [DX_WIDTH-1:0]      wr_dx,
  input  logic [DY_WIDTH-1:0]      wr_dy,
  input  logic [1:0]               wr_mode,
  input  logic                     enable_update,
  output logic [N_SPRITES*w_x-1:0] sprite_x,
  output logic [N_SPRITES*w_y-1:0] sprite_y,
  output logic [N_SPRITES-1:0]     edge_hit,
  output logic                     busy
);

  localparam logic [w_idx-1:0] LAST_IDX = w_idx'(N_SPRITES - 1);

  logic [w_x-1:0]      x_q  [N_SPRITES];
  logic [w_x-1:0]      x_d  [N_SPRITES];
  logic [w_y-1:0]      y_q  [N_SPRITES];
  logic [w_y-1:0]      y_d  [N_SPRITES];
  logic [DX_WIDTH-1:0] dx_q [N_SPRITES];
  logic [DX_WIDTH-1:0] dx_d [N_SPRITES];
  logic [DY_WIDTH-1:0] dy_q [N_SPRITES];
  logic [DY_WIDTH-1:0] dy_d [N_SPRITES];
  edge_mode_e          mode_q [N_SPRITES];
  edge_mode_e          mode_d [N_SPRITES];

  sweep_state_e         state_q;
  logic [w_idx-1:0]     idx_q;
  logic                 busy_q;
  logic [N_SPRITES-1:0] edge_hit_q;

  logic                strobe;
  logic                wr_valid;
  logic                collide;
  logic                do_step;
  logic [w_x-1:0]      step_x;
  logic [w_y-1:0]      step_y;
  logic [DX_WIDTH-1:0] step_dx;
  logic [DY_WIDTH-1:0] step_dy;
  logic                hit_x;
  logic                hit_y;

  game_strobe #(
    .width (strobe_to_update_xy_counter_width)
  ) u_strobe (
    .clk_i    (clk),
    .rst_i    (~rst_n),
    .strobe_o (strobe)
  );

  game_sprite_axis_step #(
    .W      (w_x),
    .SW     (DX_WIDTH),
    .LIMIT  (screen_width - SPRITE_WIDTH),
    .SCREEN (screen_width)
  ) u_step_x (
    .pos_i   (x_q[idx_q]),
    .speed_i (dx_q[idx_q]),
    .mode_i  (mode_q[idx_q]),
    .pos_o   (step_x),
    .speed_o (step_dx),
    .hit_o   (hit_x)
  );

  game_sprite_axis_step #(
    .W      (w_y),
    .SW     (DY_WIDTH),
    .LIMIT  (screen_height - SPRITE_HEIGHT),
    .SCREEN (screen_height)
  ) u_step_y (
    .pos_i   (y_q[idx_q]),
    .speed_i (dy_q[idx_q]),
    .mode_i  (mode_q[idx_q]),
    .pos_o   (step_y),
    .speed_o (step_dy),
    .hit_o   (hit_y)
  );

  // Any write aimed at the sprite under update cancels that sprite's step.
  assign wr_valid = int'(wr_idx) < int'(N_SPRITES);
  assign collide  = (write_xy | write_dxy | write_mode) && (wr_idx == idx_q);
  assign do_step  = (state_q == SWEEP) && !collide;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    mode_d = mode_q;
    if (do_step) begin
      x_d[idx_q]  = step_x;
      y_d[idx_q]  = step_y;
      dx_d[idx_q] = step_dx;
      dy_d[idx_q] = step_dy;
    end
    if (wr_valid) begin
      if (write_xy) begin
        x_d[wr_idx] = wr_x;
        y_d[wr_idx] = wr_y;
      end
      if (write_dxy) begin
        dx_d[wr_idx] = wr_dx;
        dy_d[wr_idx] = wr_dy;
      end
      if (write_mode) mode_d[wr_idx] = edge_mode_e'(wr_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SPRITES; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        dx_q[i]   <= '0;
        dy_q[i]   <= '0;
        mode_q[i] <= BOUNCE;
      end
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      edge_hit_q <= '0;
    end else begin
      edge_hit_q <= '0;
      case (state_q)
        IDLE: begin
          if (strobe && enable_update) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (do_step && (hit_x || hit_y)) edge_hit_q[idx_q] <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + w_idx'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sprite_x = '0;
    sprite_y = '0;
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      sprite_x[i*w_x +: w_x] = x_q[i];
      sprite_y[i*w_y +: w_y] = y_q[i];
    end
  end

  assign edge_hit = edge_hit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_game_sprite_control_multi.sv
// Bench for game_sprite_control_multi on a 64x48 screen with a 16-cycle strobe;
// each sweep is checked cycle by cycle against an integer motion model.
module tb_game_sprite_control_multi;

  localparam int NS   = 4;
  localparam int WX   = 6;
  localparam int WY   = 6;
  localparam int SCRW = 64;
  localparam int SCRH = 48;
  localparam int LX   = 56;
  localparam int LY   = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       wr_idx;
  logic             write_xy, write_dxy, write_mode;
  logic [WX-1:0]    wr_x;
  logic [WY-1:0]    wr_y;
  logic [3:0]       wr_dx, wr_dy;
  logic [1:0]       wr_mode;
  logic             enable_update;
  logic [NS*WX-1:0] sprite_x;
  logic [NS*WY-1:0] sprite_y;
  logic [NS-1:0]    edge_hit;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  int mx [NS];
  int my [NS];
  int mdx[NS];
  int mdy[NS];
  int mm [NS];

  always #5 clk = ~clk;

  game_sprite_control_multi #(
    .N_SPRITES                         (NS),
    .SPRITE_WIDTH                      (8),
    .SPRITE_HEIGHT                     (8),
    .DX_WIDTH                          (4),
    .DY_WIDTH                          (4),
    .screen_width                      (SCRW),
    .screen_height                     (SCRH),
    .strobe_to_update_xy_counter_width (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_idx        (wr_idx),
    .write_xy      (write_xy),
    .write_dxy     (write_dxy),
    .write_mode    (write_mode),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_dx         (wr_dx),
    .wr_dy         (wr_dy),
    .wr_mode       (wr_mode),
    .enable_update (enable_update),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .edge_hit      (edge_hit),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int neg_sat(input int v);
    return (v == -8) ? 7 : -v;
  endfunction

  // Reference motion rule for one axis with plain integers.
  function automatic void ax(input int p, input int v, input int m, input int lim,
                             input int scr, output int np, output int nv, output bit h);
    int n;
    n  = p + v;
    np = p;
    nv = v;
    h  = 1'b0;
    if (m == 3) return;
    if (m == 1) begin
      if (n < 0)          begin np = n + scr; h = 1'b1; end
      else if (n >= scr)  begin np = n - scr; h = 1'b1; end
      else                np = n;
    end else begin
      if (n < 0)          begin np = 0;   nv = (m == 2) ? 0 : neg_sat(v); h = 1'b1; end
      else if (n > lim)   begin np = lim; nv = (m == 2) ? 0 : neg_sat(v); h = 1'b1; end
      else                np = n;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mm[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("%s_x%0d", tag, i), 32'(sprite_x[i*WX +: WX]), mx[i]);
      chk($sformatf("%s_y%0d", tag, i), 32'(sprite_y[i*WY +: WY]), my[i]);
    end
  endtask

  task automatic drive_wr(input int idx, input bit fxy, input bit fdxy, input bit fmode,
                          input int x, input int y, input int dx, input int dy, input int m);
    wr_idx     = 2'(idx);
    write_xy   = fxy;
    write_dxy  = fdxy;
    write_mode = fmode;
    wr_x       = 6'(x);
    wr_y       = 6'(y);
    wr_dx      = 4'(dx);
    wr_dy      = 4'(dy);
    wr_mode    = 2'(m);
  endtask

  task automatic model_wr(input int idx, input bit fxy, input bit fdxy, input bit fmode,
                          input int x, input int y, input int dx, input int dy, input int m);
    if (fxy)   begin mx[idx] = x;   my[idx] = y;   end
    if (fdxy)  begin mdx[idx] = dx; mdy[idx] = dy; end
    if (fmode) mm[idx] = m;
  endtask

  task automatic clear_wr();
    write_xy   = 1'b0;
    write_dxy  = 1'b0;
    write_mode = 1'b0;
  endtask

  task automatic idle_write(input int idx, input bit fxy, input bit fdxy, input bit fmode,
                            input int x, input int y, input int dx, input int dy, input int m);
    drive_wr(idx, fxy, fdxy, fmode, x, y, dx, dy, m);
    model_wr(idx, fxy, fdxy, fmode, x, y, dx, dy, m);
    tick();
    clear_wr();
  endtask

  task automatic rand_idle_write();
    int idx, x, y, dx, dy, m;
    bit fxy, fdxy, fmode;
    idx   = int'($urandom_range(NS - 1));
    fxy   = 1'($urandom_range(1));
    fdxy  = 1'($urandom_range(1));
    fmode = 1'($urandom_range(1));
    if (!(fxy || fdxy || fmode)) fxy = 1'b1;
    x  = int'($urandom_range(SCRW - 1));
    y  = int'($urandom_range(SCRH - 1));
    dx = int'($urandom_range(15)) - 8;
    dy = int'($urandom_range(15)) - 8;
    m  = int'($urandom_range(3));
    idle_write(idx, fxy, fdxy, fmode, x, y, dx, dy, m);
  endtask

  // Returns the number of cycles until busy rose, or 0 if it never did.
  task automatic wait_busy(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("sweep_start", 32'(busy), 1);
  endtask

  // Entered in the first sweep cycle; sprite k is stepped during the k-th cycle.
  task automatic sweep_check(input string tag, input int coll_idx, input int cx,
                             input int cy, input bit rnd);
    for (int k = 0; k < NS; k++) begin
      int widx, vx, vy, vdx, vdy, vm, nx, nv;
      bit fxy, fdxy, fmode, hx, hy, hit;
      widx = -1; fxy = 1'b0; fdxy = 1'b0; fmode = 1'b0;
      vx = 0; vy = 0; vdx = 0; vdy = 0; vm = 0;
      if (k == coll_idx) begin
        widx = k; fxy = 1'b1; vx = cx; vy = cy;
      end else if (rnd && $urandom_range(9) < 3) begin
        widx  = int'($urandom_range(NS - 1));
        fxy   = 1'($urandom_range(1));
        fdxy  = 1'($urandom_range(1));
        fmode = 1'($urandom_range(1));
        if (!(fxy || fdxy || fmode)) fxy = 1'b1;
        vx  = int'($urandom_range(SCRW - 1));
        vy  = int'($urandom_range(SCRH - 1));
        vdx = int'($urandom_range(15)) - 8;
        vdy = int'($urandom_range(15)) - 8;
        vm  = int'($urandom_range(3));
      end
      hit = 1'b0;
      if (widx != k) begin
        ax(mx[k], mdx[k], mm[k], LX, SCRW, nx, nv, hx);
        mx[k] = nx; mdx[k] = nv;
        ax(my[k], mdy[k], mm[k], LY, SCRH, nx, nv, hy);
        my[k] = nx; mdy[k] = nv;
        hit = hx || hy;
      end
      if (widx >= 0) begin
        drive_wr(widx, fxy, fdxy, fmode, vx, vy, vdx, vdy, vm);
        model_wr(widx, fxy, fdxy, fmode, vx, vy, vdx, vdy, vm);
      end
      tick();
      clear_wr();
      chk($sformatf("%s_hit_c%0d", tag, k), 32'(edge_hit), hit ? (1 << k) : 0);
      chk($sformatf("%s_busy_c%0d", tag, k), 32'(busy), (k < NS - 1) ? 1 : 0);
      check_all(tag);
    end
  endtask

  initial begin
    int n;
    int busy_seen;

    rst_n = 1'b0;
    enable_update = 1'b1;
    wr_idx = '0; wr_x = '0; wr_y = '0; wr_dx = '0; wr_dy = '0; wr_mode = '0;
    clear_wr();
    model_reset();

    repeat (3) tick();
    check_all("rst");
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hit", 32'(edge_hit), 0);
    rst_n = 1'b1;

    wait_busy(n);
    chk("first_strobe_cycles", n, 16);
    sweep_check("s0", -1, 0, 0, 1'b0);

    idle_write(0, 1, 1, 1, 54, 20,  3, 0, 0);
    idle_write(1, 1, 1, 1, 62, 10,  4, 0, 1);
    idle_write(2, 1, 1, 1, 20, 38,  0, 5, 2);
    idle_write(3, 1, 1, 1,  0,  5, -8, 0, 0);
    wait_busy(n);
    sweep_check("s1", -1, 0, 0, 1'b0);
    chk("bounce_x0", 32'(sprite_x[0 +: WX]), 56);
    chk("wrap_x1", 32'(sprite_x[6 +: WX]), 2);
    chk("stop_y2", 32'(sprite_y[12 +: WY]), 40);
    chk("sat_x3", 32'(sprite_x[18 +: WX]), 0);

    idle_write(1, 1, 1, 0, 1, 10, -4, 0, 0);
    wait_busy(n);
    sweep_check("s2", -1, 0, 0, 1'b0);
    chk("bounce_back_x0", 32'(sprite_x[0 +: WX]), 53);
    chk("wrap_neg_x1", 32'(sprite_x[6 +: WX]), 61);
    chk("stop_hold_y2", 32'(sprite_y[12 +: WY]), 40);
    chk("sat_pos_x3", 32'(sprite_x[18 +: WX]), 7);

    wait_busy(n);
    sweep_check("coll", 2, 10, 10, 1'b0);
    chk("coll_x2", 32'(sprite_x[12 +: WX]), 10);
    chk("coll_y2", 32'(sprite_y[12 +: WY]), 10);

    repeat (12) begin
      repeat ($urandom_range(3)) rand_idle_write();
      wait_busy(n);
      sweep_check("rnd", -1, 0, 0, 1'b1);
    end

    wait_busy(n);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_hit", 32'(edge_hit), 0);
    repeat (2) tick();
    check_all("mid_rst_hold");
    rst_n = 1'b1;

    enable_update = 1'b0;
    idle_write(0, 1, 1, 1, 5, 5, 2, 0, 0);
    busy_seen = 0;
    repeat (20) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    chk("gated_busy", busy_seen, 0);
    check_all("gated");

    enable_update = 1'b1;
    wait_busy(n);
    sweep_check("reen", -1, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
